// File: rtl/ds1302_pkg.sv
// Shared types and constants for the DS1302 time scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Time bundles are packed {year,week,month,date,hour,minute,second},
// one BCD byte per field. Bit 7 of the seconds byte is the chip's
// clock-halt flag.
package ds1302_pkg;

  typedef logic [55:0] time_bcd_t;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_CHK,
    ST_INIT,
    ST_RUN,
    ST_WR,
    ST_RBK
  } sched_state_t;

  localparam int SEC_OFS  = 0;
  localparam int MIN_OFS  = 8;
  localparam int HOUR_OFS = 16;
  localparam int DATE_OFS = 24;
  localparam int MON_OFS  = 32;
  localparam int WEEK_OFS = 40;
  localparam int YEAR_OFS = 48;
  localparam int CH_BIT   = 7;

  localparam time_bcd_t DEFAULT_TIME = 56'h24000809115956;

  // A time written to the chip must leave the oscillator running.
  function automatic time_bcd_t clr_ch(input time_bcd_t t);
    time_bcd_t r;
    r = t;
    r[SEC_OFS + CH_BIT] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ds1302_time_sched_if.sv
// Request/ack bus between the time scheduler and ds1302_wr_ctrl.
// Latency: n/a (wiring only).
// Backpressure: level req held until a 1-cycle ack from the controller.
//
// master (scheduler): drives write_time_req, write_time, read_time_req;
//                     receives write_time_ack, read_time_ack, read_time.
// slave  (wr_ctrl)  : the mirror image.
interface ds1302_time_sched_if;
  import ds1302_pkg::*;

  logic      write_time_req;
  time_bcd_t write_time;
  logic      write_time_ack;
  logic      read_time_req;
  logic      read_time_ack;
  time_bcd_t read_time;

  modport master (
    output write_time_req, write_time, read_time_req,
    input  write_time_ack, read_time_ack, read_time
  );

  modport slave (
    input  write_time_req, write_time, read_time_req,
    output write_time_ack, read_time_ack, read_time
  );

endinterface

// File: rtl/ds1302_sched_timer.sv
// Poll wrap counter plus per-transaction timeout counter.
// Latency: poll_wrap/txn_expired are combinational decodes of registered counters.
// Backpressure: none; counters free-run regardless of the bus.
//
// Ports:
//   ds1302_clk, ds1302_rst : clock, synchronous active-high reset
//   txn_clr                : restart the transaction counter (entry into a bus state)
//   poll_wrap              : high for the one cycle the poll counter sits at its last value
//   txn_expired            : transaction counter has reached TIMEOUT_CYCLES-1
module ds1302_sched_timer #(
  parameter int POLL_CYCLES    = 5_000_000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic ds1302_clk,
  input  logic ds1302_rst,
  input  logic txn_clr,
  output logic poll_wrap,
  output logic txn_expired
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] txn_cnt;

  assign poll_wrap   = (poll_cnt == POLL_LAST);
  assign txn_expired = (txn_cnt == TMO_LAST);

  always_ff @(posedge ds1302_clk) begin
    if (ds1302_rst || poll_wrap) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

  // Saturates so it never wraps back to zero while idle in RUN/BOOT.
  always_ff @(posedge ds1302_clk) begin
    if (ds1302_rst || txn_clr) begin
      txn_cnt <= '0;
    end else if (!txn_expired) begin
      txn_cnt <= txn_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ds1302_time_sched.sv
// Boot check, periodic poll and user set-time sequencer in front of ds1302_wr_ctrl.
// Latency: req rises on the edge entering a bus state; outputs update on the ack edge.
// Backpressure: level req held until the controller acks or the transaction times out.
//
// Ports:
//   ds1302_clk, ds1302_rst : clock, synchronous active-high reset
//   set_req/set_time       : 1-cycle request to write set_time (latest request wins)
//   set_ack                : 1-cycle pulse when the user write completes
//   wr_bus                 : request/ack bus to ds1302_wr_ctrl (master side)
//   time_out/time_valid    : last good read time and its valid flag
//   time_upd               : 1-cycle pulse when time_out changes
//   busy                   : scheduler is in any state other than RUN
//   timeout_err            : 1-cycle pulse when a bus transaction times out
module ds1302_time_sched #(
  parameter int          POLL_CYCLES    = 5_000_000,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter logic [55:0] DEFAULT_TIME   = ds1302_pkg::DEFAULT_TIME
) (
  input  logic                   ds1302_clk,
  input  logic                   ds1302_rst,
  input  logic                   set_req,
  input  ds1302_pkg::time_bcd_t  set_time,
  output logic                   set_ack,
  ds1302_time_sched_if.master    wr_bus,
  output ds1302_pkg::time_bcd_t  time_out,
  output logic                   time_valid,
  output logic                   time_upd,
  output logic                   busy,
  output logic                   timeout_err
);
  import ds1302_pkg::*;

  sched_state_t state_q, state_d;

  logic      rd_req_q, wr_req_q;
  time_bcd_t wr_time_q, pend_time_q;
  logic      set_pending_q, poll_due_q;

  logic rd_ack, wr_ack, rd_ch;
  logic start_rd, start_wr, load_default, latch_rd, wr_done, tmo;
  logic poll_wrap, txn_expired;

  // Acks are only meaningful while our own request is up.
  assign rd_ack = rd_req_q & wr_bus.read_time_ack;
  assign wr_ack = wr_req_q & wr_bus.write_time_ack;
  assign rd_ch  = wr_bus.read_time[SEC_OFS + CH_BIT];

  assign wr_bus.read_time_req  = rd_req_q;
  assign wr_bus.write_time_req = wr_req_q;
  assign wr_bus.write_time     = wr_time_q;

  ds1302_sched_timer #(
    .POLL_CYCLES    (POLL_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .ds1302_clk  (ds1302_clk),
    .ds1302_rst  (ds1302_rst),
    .txn_clr     (start_rd | start_wr),
    .poll_wrap   (poll_wrap),
    .txn_expired (txn_expired)
  );

  always_ff @(posedge ds1302_clk) begin
    if (ds1302_rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // start_rd/start_wr mark entry into a bus state, including re-entry of
  // CHK after a boot-time timeout; they raise the req and restart the timer.
  always_comb begin
    state_d      = state_q;
    start_rd     = 1'b0;
    start_wr     = 1'b0;
    load_default = 1'b0;
    latch_rd     = 1'b0;
    wr_done      = 1'b0;
    tmo          = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d  = ST_CHK;
        start_rd = 1'b1;
      end
      ST_CHK, ST_RBK: begin
        if (rd_ack) begin
          if (rd_ch) begin
            state_d      = ST_INIT;
            start_wr     = 1'b1;
            load_default = 1'b1;
          end else begin
            state_d  = ST_RUN;
            latch_rd = 1'b1;
          end
        end else if (txn_expired) begin
          tmo = 1'b1;
          if (state_q == ST_CHK) begin
            state_d  = ST_CHK;
            start_rd = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_INIT: begin
        if (wr_ack) begin
          state_d  = ST_RBK;
          start_rd = 1'b1;
        end else if (txn_expired) begin
          tmo      = 1'b1;
          state_d  = ST_CHK;
          start_rd = 1'b1;
        end
      end
      ST_RUN: begin
        if (set_pending_q) begin
          state_d  = ST_WR;
          start_wr = 1'b1;
        end else if (poll_due_q) begin
          state_d  = ST_RBK;
          start_rd = 1'b1;
        end
      end
      ST_WR: begin
        if (wr_ack) begin
          state_d  = ST_RBK;
          start_rd = 1'b1;
          wr_done  = 1'b1;
        end else if (txn_expired) begin
          // set_pending stays up, so RUN re-issues the write.
          tmo     = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge ds1302_clk) begin
    if (ds1302_rst) begin
      rd_req_q      <= 1'b0;
      wr_req_q      <= 1'b0;
      wr_time_q     <= '0;
      pend_time_q   <= '0;
      set_pending_q <= 1'b0;
      poll_due_q    <= 1'b0;
      time_out      <= '0;
      time_valid    <= 1'b0;
      time_upd      <= 1'b0;
      set_ack       <= 1'b0;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (start_rd) begin
        rd_req_q <= 1'b1;
      end else if (rd_ack || tmo) begin
        rd_req_q <= 1'b0;
      end

      if (start_wr) begin
        wr_req_q  <= 1'b1;
        wr_time_q <= load_default ? clr_ch(DEFAULT_TIME) : pend_time_q;
      end else if (wr_ack || tmo) begin
        wr_req_q <= 1'b0;
      end

      // A request landing on the completing ack re-arms with the new data.
      if (set_req) begin
        set_pending_q <= 1'b1;
        pend_time_q   <= set_time;
      end else if (wr_done) begin
        set_pending_q <= 1'b0;
      end

      // Any RBK entry serves an outstanding poll, including the readback after WR.
      if (start_rd && (state_d == ST_RBK)) begin
        poll_due_q <= 1'b0;
      end else if (poll_wrap) begin
        poll_due_q <= 1'b1;
      end

      time_upd <= latch_rd;
      if (latch_rd) begin
        time_out   <= wr_bus.read_time;
        time_valid <= 1'b1;
      end

      set_ack     <= wr_done;
      timeout_err <= tmo;
      busy        <= (state_d != ST_RUN);
    end
  end

endmodule

// File: tb/tb_ds1302_time_sched.sv
// Self-checking bench for ds1302_time_sched with a behavioural wr_ctrl model.
// Latency: n/a.
// Backpressure: the model holds acks off for a programmable number of cycles.
module tb_ds1302_time_sched;
  import ds1302_pkg::*;

  localparam int POLL = 100;
  localparam int TMO  = 150;

  localparam logic [55:0] DEF_T  = 56'h24000809115956;
  localparam logic [55:0] HALT_T = 56'h24010101000080;
  localparam logic [55:0] RUN_T  = 56'h25030714102030;
  localparam logic [55:0] SET3_T = 56'h25010312080000;
  localparam logic [55:0] A_T    = 56'h25020101000000;
  localparam logic [55:0] B_T    = 56'h25020202000000;
  localparam logic [55:0] T5_T   = 56'h25051231235900;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_req = 1'b0;
  logic [55:0] set_time = '0;
  logic        set_ack, time_valid, time_upd, busy, timeout_err;
  logic [55:0] time_out;

  ds1302_time_sched_if bus();

  ds1302_time_sched #(
    .POLL_CYCLES    (POLL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .ds1302_clk  (clk),
    .ds1302_rst  (rst),
    .set_req     (set_req),
    .set_time    (set_time),
    .set_ack     (set_ack),
    .wr_bus      (bus),
    .time_out    (time_out),
    .time_valid  (time_valid),
    .time_upd    (time_upd),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [55:0] exp_wr_q[$];
  logic [55:0] exp_upd_q[$];

  int          rd_lat = 4;
  int          wr_lat = 5;
  bit          wr_noack = 1'b0;
  logic [55:0] chip_time = HALT_T;
  int          rd_count = 0, wr_count = 0;
  int          n_upd = 0, n_set_ack = 0, n_tmo = 0;

  // Controller model: acks after a latency, records writes, serves reads.
  initial begin : bfm
    int rd_wait, wr_wait;
    logic [55:0] e;
    rd_wait = 0;
    wr_wait = 0;
    bus.read_time_ack  = 1'b0;
    bus.write_time_ack = 1'b0;
    bus.read_time      = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.read_time_ack  = 1'b0;
      bus.write_time_ack = 1'b0;
      if (bus.read_time_req === 1'b1) begin
        rd_wait++;
        if (rd_wait >= rd_lat) begin
          rd_wait = 0;
          bus.read_time     = chip_time;
          bus.read_time_ack = 1'b1;
          rd_count++;
          if (chip_time[7] == 1'b0) exp_upd_q.push_back(chip_time);
        end
      end else begin
        rd_wait = 0;
      end
      if (bus.write_time_req === 1'b1 && !wr_noack) begin
        wr_wait++;
        if (wr_wait >= wr_lat) begin
          wr_wait = 0;
          bus.write_time_ack = 1'b1;
          wr_count++;
          n_checks++;
          if (exp_wr_q.size() == 0) begin
            n_fail++;
            $display("FAIL write_data: got unexpected write %h", bus.write_time);
          end else begin
            e = exp_wr_q.pop_front();
            if (bus.write_time !== e) begin
              n_fail++;
              $display("FAIL write_data: got %h expected %h", bus.write_time, e);
            end
          end
          chip_time = bus.write_time;
        end
      end else begin
        wr_wait = 0;
      end
    end
  end

  // Output monitor: time updates against the scoreboard, req exclusivity.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (bus.write_time_req === 1'b1 && bus.read_time_req === 1'b1) begin
        n_fail++;
        $display("FAIL req_exclusive: write_time_req and read_time_req both 1");
      end
    end
    if (time_upd === 1'b1) begin
      n_upd++;
      n_checks++;
      if (exp_upd_q.size() == 0) begin
        n_fail++;
        $display("FAIL time_upd: unexpected update time_out=%h", time_out);
      end else if (time_out !== exp_upd_q[0]) begin
        n_fail++;
        $display("FAIL time_upd: time_out=%h expected %h", time_out, exp_upd_q[0]);
        void'(exp_upd_q.pop_front());
      end else begin
        void'(exp_upd_q.pop_front());
      end
    end
    if (set_ack === 1'b1) n_set_ack++;
    if (timeout_err === 1'b1) n_tmo++;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic wait_busy_low(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rd_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.read_time_req === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_wr_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.write_time_req === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_set_ack(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (set_ack === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset(input logic [55:0] t);
    chip_time = t;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [6:0] flags;
    chip_time = HALT_T;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    flags = {bus.write_time_req, bus.read_time_req, time_valid, time_upd, busy, set_ack, timeout_err};
    n_checks++;
    if (flags !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000000", flags);
    end
    n_checks++;
    if (time_out !== 56'h0) begin
      n_fail++; $display("FAIL reset_time_out: got %h expected 0", time_out);
    end
    n_checks++;
    if (bus.write_time !== 56'h0) begin
      n_fail++; $display("FAIL reset_write_time: got %h expected 0", bus.write_time);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.read_time_req !== 1'b1 || busy !== 1'b1 || bus.write_time_req !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_first_read: rd_req=%b busy=%b wr_req=%b expected 1 1 0",
               bus.read_time_req, busy, bus.write_time_req);
    end
  endtask

  task automatic test_ch_boot;
    bit ok;
    exp_wr_q.push_back(DEF_T);
    wait_wr_req(50, ok);
    #1;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ch_boot_write_req: no write request seen"); end
    n_checks++;
    if (time_valid !== 1'b0 || n_upd != 0 || rd_count != 1) begin
      n_fail++;
      $display("FAIL ch_boot_not_valid: valid=%b upd=%0d reads=%0d expected 0 0 1",
               time_valid, n_upd, rd_count);
    end
    wait_busy_low(100, ok);
    #1;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL ch_boot_run: busy never dropped"); end
    n_checks++;
    if (wr_count != 1 || rd_count != 2) begin
      n_fail++; $display("FAIL ch_boot_counts: writes=%0d reads=%0d expected 1 2", wr_count, rd_count);
    end
    n_checks++;
    if (time_valid !== 1'b1 || time_out !== DEF_T) begin
      n_fail++; $display("FAIL ch_boot_time: valid=%b time_out=%h expected 1 %h", time_valid, time_out, DEF_T);
    end
  endtask

  task automatic test_running;
    bit ok;
    int r0, w0, u0;
    w0 = wr_count;
    r0 = rd_count;
    do_reset(RUN_T);
    wait_busy_low(50, ok);
    #1;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL run_boot: busy never dropped"); end
    n_checks++;
    if (wr_count != w0 || rd_count != r0 + 1) begin
      n_fail++;
      $display("FAIL run_boot_counts: writes=%0d reads=%0d expected %0d %0d", wr_count, rd_count, w0, r0 + 1);
    end
    n_checks++;
    if (time_valid !== 1'b1 || time_out !== RUN_T) begin
      n_fail++; $display("FAIL run_boot_time: valid=%b time_out=%h expected 1 %h", time_valid, time_out, RUN_T);
    end
    r0 = rd_count;
    u0 = n_upd;
    repeat (3 * POLL) @(negedge clk);
    #1;
    n_checks++;
    if (rd_count - r0 != 3 || n_upd - u0 != 3) begin
      n_fail++;
      $display("FAIL poll_rate: reads=%0d updates=%0d in %0d cycles expected 3 3",
               rd_count - r0, n_upd - u0, 3 * POLL);
    end
    n_checks++;
    if (wr_count != w0) begin
      n_fail++; $display("FAIL poll_no_write: writes=%0d expected %0d", wr_count, w0);
    end
  endtask

  task automatic test_set_during_read;
    bit ok;
    int r0, s0;
    wait_rd_req(POLL + 50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL set_read_start: no poll read seen"); end
    r0 = rd_count;
    s0 = n_set_ack;
    set_req = 1'b1;
    set_time = SET3_T;
    exp_wr_q.push_back(SET3_T);
    @(negedge clk);
    set_req = 1'b0;
    wait_set_ack(100, ok);
    n_checks++;
    if (!ok || rd_count != r0 + 1) begin
      n_fail++; $display("FAIL set_order: ack_seen=%b reads=%0d expected 1 %0d", ok, rd_count - r0, 1);
    end
    wait_busy_low(50, ok);
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (rd_count != r0 + 2 || time_out !== SET3_T) begin
      n_fail++;
      $display("FAIL set_readback: reads=%0d time_out=%h expected 2 %h", rd_count - r0, time_out, SET3_T);
    end
    n_checks++;
    if (n_set_ack - s0 != 1) begin
      n_fail++; $display("FAIL set_ack_once: pulses=%0d expected 1", n_set_ack - s0);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int r0, w0, s0;
    wr_lat = POLL;
    w0 = wr_count;
    r0 = rd_count;
    s0 = n_set_ack;
    do_reset(RUN_T);
    wait_rd_req(10, ok);
    set_req = 1'b1;
    set_time = A_T;
    @(negedge clk);
    set_time = B_T;
    exp_wr_q.push_back(B_T);
    @(negedge clk);
    set_req = 1'b0;
    wait_set_ack(3 * POLL, ok);
    n_checks++;
    if (!ok || wr_count != w0 + 1) begin
      n_fail++; $display("FAIL b2b_one_write: ack_seen=%b writes=%0d expected 1 1", ok, wr_count - w0);
    end
    wait_busy_low(50, ok);
    #1;
    n_checks++;
    if (rd_count != r0 + 2 || time_out !== B_T) begin
      n_fail++;
      $display("FAIL b2b_readback: reads=%0d time_out=%h expected 2 %h", rd_count - r0, time_out, B_T);
    end
    repeat (60) @(negedge clk);
    #1;
    n_checks++;
    if (rd_count != r0 + 2 || n_set_ack - s0 != 1) begin
      n_fail++;
      $display("FAIL b2b_no_extra_read: reads=%0d set_acks=%0d expected 2 1", rd_count - r0, n_set_ack - s0);
    end
    wr_lat = 5;
  endtask

  task automatic test_timeout;
    bit ok;
    int hi, t0;
    wr_noack = 1'b1;
    t0 = n_tmo;
    @(negedge clk);
    set_req = 1'b1;
    set_time = T5_T;
    exp_wr_q.push_back(T5_T);
    @(negedge clk);
    set_req = 1'b0;
    wait_wr_req(50, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL tmo_write_req: no write request seen"); end
    hi = 1;
    for (int i = 0; i < 3 * TMO; i++) begin
      @(negedge clk);
      if (bus.write_time_req === 1'b1) hi++;
      else break;
    end
    n_checks++;
    if (hi != TMO) begin
      n_fail++; $display("FAIL tmo_req_width: req high %0d cycles expected %0d", hi, TMO);
    end
    n_checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL tmo_pulse: timeout_err=%b busy=%b expected 1 0", timeout_err, busy);
    end
    @(negedge clk);
    n_checks++;
    if (bus.write_time_req !== 1'b1 || bus.write_time !== T5_T) begin
      n_fail++;
      $display("FAIL tmo_retry: wr_req=%b write_time=%h expected 1 %h", bus.write_time_req, bus.write_time, T5_T);
    end
    wr_noack = 1'b0;
    wait_set_ack(50, ok);
    #1;
    n_checks++;
    if (!ok || n_tmo - t0 != 1) begin
      n_fail++; $display("FAIL tmo_recover: ack_seen=%b timeouts=%0d expected 1 1", ok, n_tmo - t0);
    end
    wait_busy_low(50, ok);
  endtask

  task automatic test_reset_mid_read;
    bit ok;
    logic [7:0] flags;
    rd_lat = 20;
    wait_rd_req(2 * POLL, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mid_rst_read: no read request seen"); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    flags = {bus.write_time_req, bus.read_time_req, time_valid, time_upd, busy, set_ack, timeout_err, 1'b0};
    n_checks++;
    if (flags !== 8'b0 || time_out !== 56'h0 || bus.write_time !== 56'h0) begin
      n_fail++;
      $display("FAIL mid_rst_outputs: flags=%b time_out=%h write_time=%h expected all 0",
               flags, time_out, bus.write_time);
    end
    @(negedge clk);
    rd_lat = 4;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.read_time_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_restart: rd_req=%b expected 1", bus.read_time_req);
    end
    wait_busy_low(50, ok);
    #1;
    n_checks++;
    if (!ok || time_valid !== 1'b1 || time_out !== T5_T) begin
      n_fail++;
      $display("FAIL mid_rst_reboot: valid=%b time_out=%h expected 1 %h", time_valid, time_out, T5_T);
    end
  endtask

  initial begin
    test_reset();
    test_ch_boot();
    test_running();
    test_set_during_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid_read();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_wr_q.size() != 0 || exp_upd_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: writes left %0d updates left %0d expected 0 0",
               exp_wr_q.size(), exp_upd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
